// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter supporting LSR/LSL/ASR/ROR, with one register stage per shift-amount bit.
// The largest power-of-two shift is applied first. A single global stall freezes every stage together.
module barrel_shifter_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [SHW-1:0]   in_amt_i,
    input  logic [1:0]       in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       out_mode_o
);

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_LSL = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    logic [WIDTH-1:0] data_q  [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic [SHW-1:0]   amt_q   [SHW];
    logic [SHW-1:0]   amt_d   [SHW];
    logic [1:0]       mode_q  [SHW];
    logic [1:0]       mode_d  [SHW];
    logic [SHW-1:0]   valid_q;
    logic [SHW-1:0]   valid_d;

    logic [WIDTH-1:0] stgData [SHW];
    logic [SHW-1:0]   stgAmt  [SHW];
    logic [1:0]       stgMode [SHW];
    logic             advance;

    function automatic logic [WIDTH-1:0] shiftStage(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       m,
                                                    input int               k);
        logic [WIDTH-1:0] r;
        case (mode_e'(m))
            MODE_LSR: r = d >> k;
            MODE_LSL: r = d << k;
            MODE_ASR: r = $signed(d) >>> k;
            default:  r = (d >> k) | (d << (WIDTH - k));
        endcase
        return r;
    endfunction

    // The amount travels left-aligned, so every stage tests the MSB of what it receives.
    always_comb begin
        stgData[0] = in_data_i;
        stgAmt[0]  = in_amt_i;
        stgMode[0] = in_mode_i;
        valid_d[0] = in_valid_i;
        for (int s = 1; s < SHW; s++) begin
            stgData[s] = data_q[s-1];
            stgAmt[s]  = amt_q[s-1];
            stgMode[s] = mode_q[s-1];
            valid_d[s] = valid_q[s-1];
        end
        for (int s = 0; s < SHW; s++) begin
            data_d[s] = stgAmt[s][SHW-1] ? shiftStage(stgData[s], stgMode[s], 1 << (SHW - 1 - s))
                                         : stgData[s];
            amt_d[s]  = stgAmt[s] << 1;
            mode_d[s] = stgMode[s];
        end
    end

    assign advance     = !valid_q[SHW-1] || out_ready_i;
    assign in_ready_o  = advance;
    assign out_valid_o = valid_q[SHW-1];
    assign out_data_o  = data_q[SHW-1];
    assign out_mode_o  = mode_q[SHW-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int s = 0; s < SHW; s++) begin
                data_q[s] <= '0;
                amt_q[s]  <= '0;
                mode_q[s] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            for (int s = 0; s < SHW; s++) begin
                data_q[s] <= data_d[s];
                amt_q[s]  <= amt_d[s];
                mode_q[s] <= mode_d[s];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe: an 8-bit instance for hand-computed vectors,
// and a 32-bit instance checked against a bit-level reference model under random back-pressure.
module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;

    logic       inValid, inReady, outValid, outReady;
    logic [7:0] inData, outData;
    logic [2:0] inAmt;
    logic [1:0] inMode, outMode;

    logic        wInValid, wInReady, wOutValid, wOutReady;
    logic [31:0] wInData, wOutData;
    logic [4:0]  wInAmt;
    logic [1:0]  wInMode, wOutMode;

    int checkCount = 0;
    int passCount  = 0;

    barrel_shifter_pipe #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_ni(rstN),
        .in_valid_i(inValid), .in_ready_o(inReady),
        .in_data_i(inData), .in_amt_i(inAmt), .in_mode_i(inMode),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .out_data_o(outData), .out_mode_o(outMode)
    );

    barrel_shifter_pipe #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_ni(rstN),
        .in_valid_i(wInValid), .in_ready_o(wInReady),
        .in_data_i(wInData), .in_amt_i(wInAmt), .in_mode_i(wInMode),
        .out_valid_o(wOutValid), .out_ready_i(wOutReady),
        .out_data_o(wOutData), .out_mode_o(wOutMode)
    );

    // Bit-by-bit reference: each output bit picks its source bit directly.
    function automatic logic [31:0] refShift(input logic [31:0] d, input int a, input logic [1:0] m);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            case (m)
                2'b00:   r[i] = (i + a < 32) ? d[i + a] : 1'b0;
                2'b01:   r[i] = (i >= a) ? d[i - a] : 1'b0;
                2'b10:   r[i] = (i + a < 32) ? d[i + a] : d[31];
                default: r[i] = d[(i + a) % 32];
            endcase
        end
        return r;
    endfunction

    // Sends one item into the empty 8-bit pipe and reports what emerged and after how many cycles.
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                                 output logic [7:0] gotData, output logic [1:0] gotMode,
                                 output int latency);
        @(negedge clk);
        inValid  = 1'b1;
        inData   = d;
        inAmt    = a;
        inMode   = m;
        outReady = 1'b1;
        latency  = -1;
        gotData  = '0;
        gotMode  = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            inValid = 1'b0;
            if (outValid === 1'b1) begin
                latency = n;
                gotData = outData;
                gotMode = outMode;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        inValid = 1'b0; inData = '0; inAmt = '0; inMode = '0; outReady = 1'b1;
        wInValid = 1'b0; wInData = '0; wInAmt = '0; wInMode = '0; wOutReady = 1'b1;
        #12;
        checkCount++;
        if (outValid !== 1'b0 || outData !== 8'h00 || outMode !== 2'b00) begin
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h mode=%b, want 0/00/00", outValid, outData, outMode);
        end else passCount++;
        checkCount++;
        if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b, want 1", inReady);
        else passCount++;
        checkCount++;
        if (wOutValid !== 1'b0 || wOutData !== 32'h0 || wInReady !== 1'b1) begin
            $display("[TB] FAIL reset_w32: got valid=%b data=%h ready=%b, want 0/0/1", wOutValid, wOutData, wInReady);
        end else passCount++;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkCount++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            $display("[TB] FAIL after_reset: got ready=%b valid=%b, want 1/0", inReady, outValid);
        end else passCount++;
    endtask

    task automatic test_modes();
        logic [7:0] expData [4] = '{8'h16, 8'hA0, 8'hF6, 8'h96};
        logic [7:0] d;
        logic [1:0] md;
        int lat;
        for (int m = 0; m < 4; m++) begin
            applyStimulus(8'hB4, 3'd3, 2'(m), d, md, lat);
            checkCount++;
            if (d !== expData[m]) $display("[TB] FAIL modes_data mode=%0d: got %h, want %h", m, d, expData[m]);
            else passCount++;
            checkCount++;
            if (md !== 2'(m)) $display("[TB] FAIL modes_out_mode mode=%0d: got %0d, want %0d", m, md, m);
            else passCount++;
            checkCount++;
            if (lat != 3) $display("[TB] FAIL modes_latency mode=%0d: got %0d, want 3", m, lat);
            else passCount++;
        end
    endtask

    task automatic test_amount_edges();
        logic [7:0] expMax [4] = '{8'h01, 8'h80, 8'hFF, 8'h03};
        logic [7:0] d;
        logic [1:0] md;
        int lat;
        for (int m = 0; m < 4; m++) begin
            applyStimulus(8'h81, 3'd0, 2'(m), d, md, lat);
            checkCount++;
            if (d !== 8'h81 || lat != 3) $display("[TB] FAIL amt0 mode=%0d: got %h lat %0d, want 81 lat 3", m, d, lat);
            else passCount++;
            applyStimulus(8'h81, 3'd7, 2'(m), d, md, lat);
            checkCount++;
            if (d !== expMax[m] || lat != 3) $display("[TB] FAIL amt7 mode=%0d: got %h lat %0d, want %h lat 3", m, d, lat, expMax[m]);
            else passCount++;
        end
    endtask

    task automatic test_streaming();
        logic [7:0] expData;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            outReady = 1'b1;
            if (i >= 3 && i <= 10) begin
                expData = 8'(2 * (i - 2));
                checkCount++;
                if (outValid !== 1'b1 || outData !== expData) begin
                    $display("[TB] FAIL stream_out cycle=%0d: got valid=%b data=%h, want 1/%h", i, outValid, outData, expData);
                end else passCount++;
            end else begin
                checkCount++;
                if (outValid !== 1'b0) $display("[TB] FAIL stream_idle cycle=%0d: got valid=%b, want 0", i, outValid);
                else passCount++;
            end
            checkCount++;
            if (inReady !== 1'b1) $display("[TB] FAIL stream_in_ready cycle=%0d: got %b, want 1", i, inReady);
            else passCount++;
            if (i < 8) begin
                inValid = 1'b1; inData = 8'(i + 1); inAmt = 3'd1; inMode = 2'b01;
            end else begin
                inValid = 1'b0;
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] expQ [$];
        logic [7:0] heldData = '0;
        logic [7:0] want;
        logic       wasStalled = 1'b0;
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            outReady = !(cyc >= 5 && cyc < 9);
            inValid  = (sent < 8);
            inData   = 8'(18 + 17 * sent);
            inAmt    = 3'd4;
            inMode   = 2'b11;
            #1;
            if (wasStalled) begin
                checkCount++;
                if (outValid !== 1'b1 || outData !== heldData) begin
                    $display("[TB] FAIL bp_hold cycle=%0d: got valid=%b data=%h, want 1/%h", cyc, outValid, outData, heldData);
                end else passCount++;
            end
            if (outValid && !outReady) begin
                checkCount++;
                if (inReady !== 1'b0) $display("[TB] FAIL bp_in_ready cycle=%0d: got %b, want 0", cyc, inReady);
                else passCount++;
            end
            wasStalled = outValid && !outReady;
            heldData   = outData;
            if (inValid && inReady) begin
                expQ.push_back({inData[3:0], inData[7:4]});
                sent++;
            end
            if (outValid && outReady) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL bp_extra cycle=%0d: got unexpected %h, want nothing", cyc, outData);
                end else begin
                    want = expQ.pop_front();
                    if (outData !== want) $display("[TB] FAIL bp_order cycle=%0d: got %h, want %h", cyc, outData, want);
                    else passCount++;
                end
                got++;
            end
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkCount++;
        if (got != 8 || sent != 8) $display("[TB] FAIL bp_count: got delivered=%0d sent=%0d, want 8/8", got, sent);
        else passCount++;
        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if (outValid !== 1'b0) $display("[TB] FAIL bp_drained: got valid=%b, want 0", outValid);
        else passCount++;
    endtask

    task automatic test_reset_mid_stream();
        logic [7:0] d;
        logic [1:0] md;
        int lat;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            outReady = 1'b1;
            inValid  = (i < 3);
            inData   = 8'(8'h11 * (i + 1));
            inAmt    = 3'd0;
            inMode   = 2'b00;
        end
        checkCount++;
        if (outValid !== 1'b1) $display("[TB] FAIL midrst_inflight: got valid=%b, want 1", outValid);
        else passCount++;
        #2 rstN = 1'b0;
        #1;
        checkCount++;
        if (outValid !== 1'b0 || outData !== 8'h00 || inReady !== 1'b1) begin
            $display("[TB] FAIL midrst_async: got valid=%b data=%h ready=%b, want 0/00/1", outValid, outData, inReady);
        end else passCount++;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(8'hF0, 3'd4, 2'b10, d, md, lat);
        checkCount++;
        if (d !== 8'hFF || md !== 2'b10 || lat != 3) begin
            $display("[TB] FAIL midrst_after: got data=%h mode=%b lat=%0d, want FF/10/3", d, md, lat);
        end else passCount++;
    endtask

    task automatic test_sweep32();
        logic [31:0] expQ [$];
        logic [31:0] want;
        logic        pending = 1'b0;
        int lat = -1;
        int sent = 0;
        int got  = 0;
        @(negedge clk);
        wOutReady = 1'b1;
        wInValid = 1'b1; wInData = 32'h8000_0001; wInAmt = 5'd31; wInMode = 2'b11;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            wInValid = 1'b0;
            if (wOutValid === 1'b1) begin
                lat = n;
                break;
            end
        end
        checkCount++;
        if (lat != 5 || wOutData !== 32'h0000_0003) begin
            $display("[TB] FAIL w32_latency: got lat=%0d data=%h, want 5/00000003", lat, wOutData);
        end else passCount++;
        for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
            @(negedge clk);
            wOutReady = ($urandom_range(0, 3) != 0);
            if (!pending && sent < 40 && $urandom_range(0, 4) != 0) begin
                wInData = $urandom;
                wInAmt  = 5'($urandom_range(0, 31));
                wInMode = 2'($urandom_range(0, 3));
                pending = 1'b1;
            end
            wInValid = pending;
            #1;
            if (wInValid && wInReady) begin
                expQ.push_back(refShift(wInData, int'(wInAmt), wInMode));
                sent++;
                pending = 1'b0;
            end
            if (wOutValid && wOutReady) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL w32_extra cycle=%0d: got unexpected %h, want nothing", cyc, wOutData);
                end else begin
                    want = expQ.pop_front();
                    if (wOutData !== want) $display("[TB] FAIL w32_data item=%0d: got %h, want %h", got, wOutData, want);
                    else passCount++;
                end
                got++;
            end
        end
        wInValid = 1'b0;
        checkCount++;
        if (got != 40) $display("[TB] FAIL w32_count: got %0d delivered, want 40", got);
        else passCount++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_modes();
        test_amount_edges();
        test_streaming();
        test_back_pressure();
        test_reset_mid_stream();
        test_sweep32();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
